// File: rtl/ascon_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ascon_pkg
// Purpose  : Constants shared by the Ascon encryptor and decryptor: the
//            Ascon-128a IV, default round counts, FSM state encoding and the
//            round-constant table with its lookup helper.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package ascon_pkg;

  localparam logic [63:0] ASCON_IV    = 64'h80800c0800000000;
  localparam int          P_A_DEFAULT = 12;
  localparam int          P_B_DEFAULT = 8;
  localparam int          ROUND_W     = 4;

  // Controller state encoding
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_INIT  = 3'd1;
  localparam logic [2:0] ST_AD    = 3'd2;
  localparam logic [2:0] ST_CT    = 3'd3;
  localparam logic [2:0] ST_FINAL = 3'd4;
  localparam logic [2:0] ST_TAG   = 3'd5;

  // Constants of the full 12-round permutation; entries 12..15 are unused.
  localparam logic [7:0] RC_TABLE [16] = '{
    8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5, 8'h96, 8'h87,
    8'h78, 8'h69, 8'h5a, 8'h4b, 8'h00, 8'h00, 8'h00, 8'h00
  };

  // A reduced permutation of n rounds uses the LAST n constants of the table.
  // rnd counts 1..n, so the table index is rnd + (11 - n), modulo 16.
  function automatic logic [7:0] round_const(input int unsigned n_rounds,
                                             input logic [ROUND_W-1:0] rnd);
    logic [ROUND_W-1:0] idx;
    idx = rnd + ROUND_W'(11 - n_rounds);
    return RC_TABLE[idx];
  endfunction

endpackage : ascon_pkg
`default_nettype wire

// File: rtl/permutation.sv
`default_nettype none
// ============================================================================
// Module   : permutation
// Purpose  : One Ascon permutation round (constant addition, 5-bit S-box
//            layer in bit-sliced form, linear diffusion layer). Purely
//            combinational.
// Ports    : in      [319:0] state before the round (x0 in bits 319:256)
//            round_c [7:0]   round constant, XORed into the low byte of x2
//            out     [319:0] state after the round
// Revision : 1.0  initial release
// ============================================================================
module permutation (
  input  logic [319:0] in,
  output logic [319:0] out,
  input  logic [7:0]   round_c
);

  function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  logic [63:0] x0, x1, x2, x3, x4;
  logic [63:0] a0, a1, a2, a3, a4;
  logic [63:0] b0, b1, b2, b3, b4;
  logic [63:0] c0, c1, c2, c3, c4;

  assign {x0, x1, x2, x3, x4} = in;

  // S-box input whitening (constant folded into x2)
  assign a0 = x0 ^ x4;
  assign a1 = x1;
  assign a2 = x2 ^ {56'd0, round_c} ^ x1;
  assign a3 = x3;
  assign a4 = x4 ^ x3;

  // chi-like nonlinear step
  assign b0 = a0 ^ (~a1 & a2);
  assign b1 = a1 ^ (~a2 & a3);
  assign b2 = a2 ^ (~a3 & a4);
  assign b3 = a3 ^ (~a4 & a0);
  assign b4 = a4 ^ (~a0 & a1);

  // S-box output whitening
  assign c0 = b0 ^ b4;
  assign c1 = b1 ^ b0;
  assign c2 = ~b2;
  assign c3 = b3 ^ b2;
  assign c4 = b4;

  assign out = {c0 ^ rotr(c0, 19) ^ rotr(c0, 28),
                c1 ^ rotr(c1, 61) ^ rotr(c1, 39),
                c2 ^ rotr(c2,  1) ^ rotr(c2,  6),
                c3 ^ rotr(c3, 10) ^ rotr(c3, 17),
                c4 ^ rotr(c4,  7) ^ rotr(c4, 41)};

endmodule : permutation
`default_nettype wire

// File: rtl/ascon_dec.sv
`default_nettype none
// ============================================================================
// Module   : ascon_dec
// Purpose  : Ascon-128a decryptor, one permutation round per clock.
//            Requests AD/ciphertext blocks with o_nxt_data, releases each
//            plaintext block on o_data/o_p, and reports the tag comparison
//            with a single o_fin/o_auth pulse.
// Ports    : clk         clock, rising edge
//            i_rst       asynchronous active-low reset
//            i_start     start request, honoured in IDLE only
//            i_k/i_n     key / nonce, sampled with i_start
//            i_tag       received tag, sampled with i_start
//            i_a_len     AD length in 128-bit blocks
//            i_m_len     ciphertext length in 128-bit blocks
//            i_data      AD or ciphertext block, valid the cycle after o_nxt_data
//            o_nxt_data  one-cycle request for the next i_data block
//            o_p/o_data  plaintext strobe and block (o_data zero otherwise)
//            o_fin       one-cycle completion pulse
//            o_auth      tag match, valid only with o_fin
// Revision : 1.0  initial release
// ============================================================================
module ascon_dec
  import ascon_pkg::*;
#(
  parameter int P_A = P_A_DEFAULT,
  parameter int P_B = P_B_DEFAULT
) (
  input  logic         clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [127:0] i_k,
  input  logic [127:0] i_n,
  input  logic [127:0] i_tag,
  input  logic [15:0]  i_a_len,
  input  logic [15:0]  i_m_len,
  input  logic [127:0] i_data,
  output logic         o_nxt_data,
  output logic         o_p,
  output logic [127:0] o_data,
  output logic         o_fin,
  output logic         o_auth
);

  localparam logic [ROUND_W-1:0] LAST_A = ROUND_W'(P_A);
  localparam logic [ROUND_W-1:0] LAST_B = ROUND_W'(P_B);
  localparam logic [ROUND_W-1:0] RND_1  = ROUND_W'(1);

  logic [2:0]         st,     st_nxt;
  logic [319:0]       s,      s_nxt;
  logic [ROUND_W-1:0] rnd,    rnd_nxt;
  logic [15:0]        a_left, a_left_nxt;
  logic [15:0]        m_left, m_left_nxt;
  logic [127:0]       key,    key_nxt;
  logic [127:0]       tag,    tag_nxt;

  logic [319:0] perm_in, perm_out;
  logic [7:0]   rc;

  permutation u_round (
    .in      (perm_in),
    .out     (perm_out),
    .round_c (rc)
  );

  always_comb begin
    st_nxt     = st;
    s_nxt      = s;
    rnd_nxt    = rnd;
    a_left_nxt = a_left;
    m_left_nxt = m_left;
    key_nxt    = key;
    tag_nxt    = tag;
    perm_in    = s;
    rc         = 8'h00;
    o_nxt_data = 1'b0;
    o_p        = 1'b0;
    o_data     = '0;
    o_fin      = 1'b0;
    o_auth     = 1'b0;

    case (st)
      ST_IDLE: begin
        if (i_start) begin
          s_nxt      = {ASCON_IV, i_k, i_n};
          key_nxt    = i_k;
          tag_nxt    = i_tag;
          a_left_nxt = i_a_len;
          m_left_nxt = i_m_len;
          rnd_nxt    = RND_1;
          st_nxt     = ST_INIT;
        end
      end

      ST_INIT: begin
        rc    = round_const(P_A, rnd);
        s_nxt = perm_out;
        if (rnd == LAST_A) begin
          // Key fold-in; with no AD the domain-separation bit lands here too.
          s_nxt      = perm_out ^ {192'd0, key} ^ {319'd0, (a_left == 16'd0)};
          rnd_nxt    = RND_1;
          o_nxt_data = (a_left != 16'd0) || (m_left != 16'd0);
          st_nxt     = (a_left != 16'd0) ? ST_AD : ST_CT;
        end else begin
          rnd_nxt = rnd + RND_1;
        end
      end

      ST_AD: begin
        rc = round_const(P_B, rnd);
        if (rnd == RND_1) perm_in = {s[319:192] ^ i_data, s[191:0]};
        s_nxt = perm_out;
        if (rnd == LAST_B) begin
          rnd_nxt    = RND_1;
          a_left_nxt = a_left - 16'd1;
          if (a_left == 16'd1) begin
            s_nxt      = perm_out ^ {319'd0, 1'b1};
            o_nxt_data = (m_left != 16'd0);
            st_nxt     = ST_CT;
          end else begin
            o_nxt_data = 1'b1;
          end
        end else begin
          rnd_nxt = rnd + RND_1;
        end
      end

      ST_CT: begin
        if (m_left == 16'd0) begin
          // Empty message: a one-cycle slot with nothing to absorb.
          rnd_nxt = RND_1;
          st_nxt  = ST_FINAL;
        end else if (m_left == 16'd1) begin
          // Last block: rate takes the ciphertext, no permutation.
          o_p        = 1'b1;
          o_data     = s[319:192] ^ i_data;
          s_nxt      = {i_data, s[191:0]};
          m_left_nxt = 16'd0;
          rnd_nxt    = RND_1;
          st_nxt     = ST_FINAL;
        end else begin
          rc = round_const(P_B, rnd);
          if (rnd == RND_1) begin
            o_p     = 1'b1;
            o_data  = s[319:192] ^ i_data;
            perm_in = {i_data, s[191:0]};
          end
          s_nxt = perm_out;
          if (rnd == LAST_B) begin
            rnd_nxt    = RND_1;
            m_left_nxt = m_left - 16'd1;
            o_nxt_data = 1'b1;
          end else begin
            rnd_nxt = rnd + RND_1;
          end
        end
      end

      ST_FINAL: begin
        rc = round_const(P_A, rnd);
        if (rnd == RND_1) perm_in = s ^ {128'd0, key, 64'd0};
        s_nxt = perm_out;
        if (rnd == LAST_A) begin
          s_nxt   = perm_out ^ {192'd0, key};
          rnd_nxt = '0;
          st_nxt  = ST_TAG;
        end else begin
          rnd_nxt = rnd + RND_1;
        end
      end

      ST_TAG: begin
        o_fin  = 1'b1;
        o_auth = (s[127:0] == tag);
        st_nxt = ST_IDLE;
      end

      default: st_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      st     <= ST_IDLE;
      s      <= '0;
      rnd    <= '0;
      a_left <= '0;
      m_left <= '0;
      key    <= '0;
      tag    <= '0;
    end else begin
      st     <= st_nxt;
      s      <= s_nxt;
      rnd    <= rnd_nxt;
      a_left <= a_left_nxt;
      m_left <= m_left_nxt;
      key    <= key_nxt;
      tag    <= tag_nxt;
    end
  end

endmodule : ascon_dec
`default_nettype wire

// File: tb/tb_ascon_dec.sv
`default_nettype none
// ============================================================================
// Module   : tb_ascon_dec
// Purpose  : Self-checking bench for ascon_dec against a sequential Ascon
//            reference model (table S-box, whole-permutation calls).
// Revision : 1.0  initial release
// ============================================================================
module tb_ascon_dec;

  localparam logic [63:0] IV = 64'h80800c0800000000;
  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
  localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
  localparam int ROT_B [5] = '{28, 39, 6, 17, 41};

  logic         clk = 1'b0;
  logic         i_rst, i_start;
  logic [127:0] i_k, i_n, i_tag, i_data;
  logic [15:0]  i_a_len, i_m_len;
  logic         o_nxt_data, o_p, o_fin, o_auth;
  logic [127:0] o_data;

  int passed = 0;
  int total  = 0;

  logic [127:0] ad_mem [8];
  logic [127:0] ct_mem [8];
  logic [127:0] pt_mem [8];
  logic [127:0] pt_exp [8];

  always #5 clk = ~clk;

  ascon_dec dut (
    .clk        (clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .i_k        (i_k),
    .i_n        (i_n),
    .i_tag      (i_tag),
    .i_a_len    (i_a_len),
    .i_m_len    (i_m_len),
    .i_data     (i_data),
    .o_nxt_data (o_nxt_data),
    .o_p        (o_p),
    .o_data     (o_data),
    .o_fin      (o_fin),
    .o_auth     (o_auth)
  );

  task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // Last nr rounds of the Ascon permutation.
  function automatic logic [319:0] perm_model(input logic [319:0] si, input int nr);
    logic [63:0] x [5];
    logic [63:0] y [5];
    logic [4:0]  col, v;
    x[0] = si[319:256]; x[1] = si[255:192]; x[2] = si[191:128];
    x[3] = si[127:64];  x[4] = si[63:0];
    for (int r = 12 - nr; r < 12; r++) begin
      x[2] = x[2] ^ {56'd0, 4'(15 - r), 4'(r)};
      for (int b = 0; b < 64; b++) begin
        col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
        v   = SBOX[col];
        for (int w = 0; w < 5; w++) y[w][b] = v[4 - w];
      end
      for (int w = 0; w < 5; w++) x[w] = y[w] ^ rotr(y[w], ROT_A[w]) ^ rotr(y[w], ROT_B[w]);
    end
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  // enc=1: pt_mem -> ct_mem ; enc=0: ct_mem -> pt_exp. Returns the tag.
  task automatic model(input logic [127:0] k, input logic [127:0] n, input int a, input int m,
                       input bit enc, output logic [127:0] tag_o);
    logic [319:0] st;
    st = perm_model({IV, k, n}, 12);
    st[127:0] ^= k;
    for (int i = 0; i < a; i++) begin
      st[319:192] ^= ad_mem[i];
      st = perm_model(st, 8);
    end
    st[0] ^= 1'b1;
    for (int j = 0; j < m; j++) begin
      if (enc) ct_mem[j] = st[319:192] ^ pt_mem[j];
      else     pt_exp[j] = st[319:192] ^ ct_mem[j];
      st[319:192] = ct_mem[j];
      if (j < m - 1) st = perm_model(st, 8);
    end
    st[191:64] ^= k;
    st = perm_model(st, 12);
    st[127:0] ^= k;
    tag_o = st[127:0];
  endtask

  // One decryption. abort_at>0 pulls reset low in that cycle instead.
  task automatic run(input string nm, input logic [127:0] k, input logic [127:0] n,
                     input logic [127:0] t, input int a, input int m,
                     input logic exp_auth, input int abort_at);
    int nreq, np, fin_cyc, bi, limit;
    logic pending, bad_req, bad_p, stray, auth_v, aborted, fin_seen;
    logic [127:0] got [8];
    logic [127:0] blk;
    nreq = 0; np = 0; fin_cyc = 0; bi = 0;
    pending = 0; bad_req = 0; bad_p = 0; stray = 0; auth_v = 0; aborted = 0; fin_seen = 0;
    blk = '0;
    for (int j = 0; j < 8; j++) got[j] = '0;
    limit = 8 * a + 8 * m + 40;
    i_k = k; i_n = n; i_tag = t; i_a_len = 16'(a); i_m_len = 16'(m); i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    for (int cyc = 1; cyc <= limit; cyc++) begin
      i_data  = pending ? blk : rnd128();
      pending = 1'b0;
      @(negedge clk);
      if (cyc == abort_at) begin
        i_rst = 1'b0;
        aborted = 1'b1;
        break;
      end
      if (o_nxt_data) begin
        if (cyc != 12 + 8 * nreq) bad_req = 1'b1;
        if (bi < a) blk = ad_mem[bi];
        else if (bi - a < 8) blk = ct_mem[bi - a];
        bi++; nreq++; pending = 1'b1;
      end
      if (o_p) begin
        if (cyc != 13 + 8 * a + 8 * np) bad_p = 1'b1;
        if (np < 8) got[np] = o_data;
        np++;
      end else if (o_data !== '0) stray = 1'b1;
      if (!o_fin && o_auth) stray = 1'b1;
      if (o_fin) begin
        fin_cyc = cyc;
        auth_v  = o_auth;
        break;
      end
      @(posedge clk); #1;
    end

    if (aborted) begin
      #1;
      check({nm, "/rst_data"}, o_data, 128'd0);
      check({nm, "/rst_ctl"}, 128'({o_nxt_data, o_p, o_fin, o_auth}), 128'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      i_rst = 1'b1;
      for (int c = 0; c < 60; c++) begin
        @(negedge clk);
        if (o_fin) fin_seen = 1'b1;
      end
      check({nm, "/no_fin"}, 128'(fin_seen), 128'd0);
    end else begin
      check({nm, "/req_cnt"}, 128'(nreq), 128'((m > 0) ? a + m : a));
      check({nm, "/req_time"}, 128'(bad_req), 128'd0);
      check({nm, "/p_cnt"}, 128'(np), 128'(m));
      check({nm, "/p_time"}, 128'(bad_p), 128'd0);
      for (int j = 0; j < m && j < 8; j++) check({nm, "/pt"}, got[j], pt_exp[j]);
      check({nm, "/idle_zero"}, 128'(stray), 128'd0);
      check({nm, "/fin_cyc"}, 128'(fin_cyc), 128'((m > 0) ? 8 * a + 8 * m + 18 : 8 * a + 26));
      check({nm, "/auth"}, 128'(auth_v), 128'(exp_auth));
      @(posedge clk); #1;
      @(negedge clk);
      check({nm, "/fin_pulse"}, 128'(o_fin), 128'd0);
    end
  endtask

  initial begin
    logic [127:0] kv, nv, tg;
    int nfin, f1, f2, ra, rm;
    logic a1, good;

    i_rst = 1'b0; i_start = 1'b0; i_k = '0; i_n = '0; i_tag = '0;
    i_a_len = '0; i_m_len = '0; i_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset/data", o_data, 128'd0);
    check("reset/ctl", 128'({o_nxt_data, o_p, o_fin, o_auth}), 128'd0);
    i_rst = 1'b1;

    // Loopback vectors: encrypt with the model, decrypt with the DUT.
    kv = 128'h000102030405060708090a0b0c0d0e0f;
    ad_mem[0] = kv;
    pt_mem[0] = rnd128();
    pt_mem[1] = rnd128();
    model(kv, kv, 1, 2, 1'b1, tg);
    pt_exp[0] = pt_mem[0];
    pt_exp[1] = pt_mem[1];
    run("loop", kv, kv, tg, 1, 2, 1'b1, 0);
    run("badtag", kv, kv, tg ^ 128'd1, 1, 2, 1'b0, 0);

    // A=0, M=1
    nv = rnd128();
    ct_mem[0] = rnd128();
    model(kv, nv, 0, 1, 1'b0, tg);
    run("a0m1", kv, nv, tg, 0, 1, 1'b1, 0);

    // A=2, M=0
    ad_mem[0] = rnd128();
    ad_mem[1] = rnd128();
    model(kv, nv, 2, 0, 1'b1, tg);
    run("a2m0", kv, nv, tg, 2, 0, 1'b1, 0);

    // Reset in FINAL (cycles 30..41 for A=1,M=2), then restart the loopback.
    ad_mem[0] = kv;
    model(kv, kv, 1, 2, 1'b1, tg);
    pt_exp[0] = pt_mem[0];
    pt_exp[1] = pt_mem[1];
    run("abort", kv, kv, tg, 1, 2, 1'b1, 35);
    run("restart", kv, kv, tg, 1, 2, 1'b1, 0);

    // i_start held high: A=M=0 runs back to back, fin at 26 then 27+26.
    nv = rnd128();
    model(kv, nv, 0, 0, 1'b1, tg);
    i_k = kv; i_n = nv; i_tag = tg; i_a_len = 16'd0; i_m_len = 16'd0; i_start = 1'b1;
    nfin = 0; f1 = 0; f2 = 0; a1 = 1'b0;
    @(posedge clk); #1;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      i_data = rnd128();
      @(negedge clk);
      if (o_fin) begin
        nfin++;
        if (nfin == 1) begin f1 = cyc; a1 = o_auth; end
        else if (nfin == 2) f2 = cyc;
      end
      @(posedge clk); #1;
    end
    check("hold/fin_cnt", 128'(nfin), 128'd2);
    check("hold/fin1", 128'(f1), 128'd26);
    check("hold/fin2", 128'(f2), 128'd53);
    check("hold/auth", 128'(a1), 128'd1);
    i_start = 1'b0;
    @(negedge clk); i_rst = 1'b0;
    @(negedge clk); i_rst = 1'b1;

    // Randomized runs against the model
    for (int it = 0; it < 5; it++) begin
      ra = int'($urandom_range(0, 3));
      rm = int'($urandom_range(0, 3));
      kv = rnd128();
      nv = rnd128();
      for (int j = 0; j < 4; j++) begin
        ad_mem[j] = rnd128();
        ct_mem[j] = rnd128();
      end
      model(kv, nv, ra, rm, 1'b0, tg);
      good = 1'($urandom_range(0, 1));
      if (!good) tg = tg ^ (128'd1 << $urandom_range(0, 127));
      run("rand", kv, nv, tg, ra, rm, good, 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_ascon_dec
`default_nettype wire

// File: doc/ascon_dec.md
ASCON_DEC -- requirements
Module: ascon_dec

Interface
REQ-001 SHALL declare parameter P_A, default 12, initialization/finalization round count.
REQ-002 SHALL declare parameter P_B, default 8, per-block round count.
REQ-003 SHALL have clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have i_rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have i_start  input  1  begin decryption; honoured only in IDLE.
REQ-006 SHALL have i_k  input  128  key; sampled with i_start.
REQ-007 SHALL have i_n  input  128  nonce; sampled with i_start.
REQ-008 SHALL have i_tag  input  128  received tag; sampled with i_start.
REQ-009 SHALL have i_a_len  input  16  AD length in 128-bit blocks; sampled with i_start.
REQ-010 SHALL have i_m_len  input  16  ciphertext length in 128-bit blocks; sampled with i_start.
REQ-011 SHALL have i_data  input  128  AD or ciphertext block; valid in the cycle after an o_nxt_data pulse.
REQ-012 SHALL have o_nxt_data  output  1  one-cycle request for the next i_data block.
REQ-013 SHALL have o_p  output  1  o_data carries a plaintext block this cycle.
REQ-014 SHALL have o_data  output  128  plaintext block when o_p=1, else zero.
REQ-015 SHALL have o_fin  output  1  one-cycle done pulse.
REQ-016 SHALL have o_auth  output  1  tag match; meaningful only while o_fin=1, else zero.

Function
REQ-017 SHALL implement Ascon-128a decryption: 320-bit state, rate = state[319:192], IV 64'h80800c0800000000, one permutation round per cycle.
REQ-018 SHALL use states IDLE, INIT, AD, CT, FINAL, TAG; encoding from shared package.
REQ-019 IDLE: on i_start, load state {IV,i_k,i_n}, latch key/tag/lengths, round counter=1, go INIT; i_start ignored in every other state.
REQ-020 INIT: P_A cycles with round constants f0,e1,...,4b; last cycle XORs key into state[127:0]; if A=0 also XORs 1 into state[0] (domain separation).
REQ-021 AD: per block P_B cycles with constants b4..4b; first cycle permutes {rate^i_data, capacity}; after last AD block XOR 1 into state[0].
REQ-022 CT, non-last block: first cycle o_p=1, o_data=rate^i_data, permutation input {i_data, capacity}; block lasts P_B cycles.
REQ-023 CT, last block: single cycle, o_p=1, o_data=rate^i_data, state rate replaced by i_data, no permutation, go FINAL.
REQ-024 M=0: after INIT/AD go directly to FINAL; no o_p pulses.
REQ-025 FINAL: P_A cycles; first round input state^{128'd0,key,64'd0}; last cycle XORs key into state[127:0]; go TAG.
REQ-026 TAG: one cycle, o_fin=1, o_auth=(state[127:0]==latched tag), o_data=0, then IDLE; computed tag never driven on o_data.
REQ-027 o_nxt_data SHALL pulse in the last cycle of INIT, of each AD block, and of each non-last CT block, only when a further AD or CT block remains.
REQ-028 Latency: o_fin asserted in cycle 8A+8M+18 after the i_start sampling edge for M>=1 (P_A=12, P_B=8); 8A+26 for M=0.
REQ-029 Plaintext SHALL be released regardless of tag result; consumer discards on o_auth=0.
REQ-030 Block counter 16 bits; A=16'hFFFF and M=16'hFFFF SHALL complete without wrap error.

Reset
REQ-031 i_rst low SHALL force IDLE, clear state, counters, key, tag, lengths; all outputs 0.
REQ-032 Reset mid-operation SHALL abort without o_fin; next i_start starts a fresh decryption.

Structure
REQ-033 Shared package ascon_pkg SHALL hold IV, P_A/P_B defaults, state encoding, round-constant table (shared with encryptor).
REQ-034 SHALL instantiate exactly one existing round sub-module permutation (in, out, round_c); no other sub-modules.
REQ-035 Implementation SHALL be one combinational next-state block plus one register block.

Verification
REQ-036 Loopback: K=N=000102..0F, A=1 (AD 0x00..0F), M=2; ciphertext/tag from ascon_enc -> o_p twice with original plaintext, o_fin at cycle 34+8, o_auth=1.
REQ-037 Same vectors, tag bit 0 flipped -> identical plaintext, o_auth=0.
REQ-038 A=0, M=1 -> no AD requests, exactly one o_nxt_data before CT, o_fin at cycle 26.
REQ-039 A=2, M=0 -> two AD requests, no o_p, o_fin at cycle 42, o_auth matches encryptor tag.
REQ-040 i_rst low during FINAL -> outputs 0 next cycle, no o_fin; restart with REQ-036 vectors passes.
REQ-041 i_start held high throughout a run -> ignored while busy; new run begins only after TAG.
